// File: rtl/uart_tx_arbiter_if.sv
// Requester-side handshake bundle for uart_tx_arbiter: two valid/data/ready channels.
// The master modport is the requester side and the slave modport is the arbiter side.
interface uart_tx_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    modport master (
        output req0_valid,
        output req0_data,
        input  req0_ready,
        output req1_valid,
        output req1_data,
        input  req1_ready
    );

    modport slave (
        input  req0_valid,
        input  req0_data,
        output req0_ready,
        input  req1_valid,
        input  req1_data,
        output req1_ready
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin UART transmitter: start, DATA_W bits LSB first, optional even parity, stop.
// Define UART_TX_PARITY_EN to insert the even parity bit between the last data bit and the stop bit.
module uart_tx_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_baud_pulse,
    uart_tx_arbiter_if.slave    bus,
    output logic                o_tx,
    output logic                o_busy,
    output logic                o_grant_id,
    output logic                o_frame_done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;
`endif

    state_t             r_state;
    logic               r_tx;
    logic               r_busy;
    logic               r_frame_done;
    logic               r_grant_id;
    logic               r_last_grant;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_shift;
`ifdef UART_TX_PARITY_EN
    logic               r_parity;
`endif

    logic               w_idle;
    logic               w_any_valid;
    logic               w_sel;
    logic               w_accept;
    logic               w_shift;
    logic [DATA_W-1:0]  w_sel_data;

    // Ready is gated by rst_n so both readys drop the instant reset asserts.
    always_comb begin
        w_idle      = rst_n && (r_state == ST_IDLE);
        w_any_valid = bus.req0_valid || bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            w_sel = ~r_last_grant;
        end else begin
            w_sel = bus.req1_valid;
        end
        w_sel_data = w_sel ? bus.req1_data : bus.req0_data;
        w_accept   = w_idle && w_any_valid;
        w_shift    = i_baud_pulse &&
                     ((r_state == ST_START) ||
                      ((r_state == ST_DATA) && (r_idx < LAST_IDX)));
    end

    assign bus.req0_ready = w_accept && !w_sel;
    assign bus.req1_ready = w_accept &&  w_sel;

    // Control FSM; every output is a register so the serial line cannot glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'b1;
            r_idx        <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_accept) begin
                        r_state      <= ST_SYNC;
                        r_busy       <= 1'b1;
                        r_grant_id   <= w_sel;
                        r_last_grant <= w_sel;
                    end
                end
                ST_SYNC: begin
                    if (i_baud_pulse) begin
                        r_state <= ST_START;
                        r_tx    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (i_baud_pulse) begin
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
                        r_idx   <= '0;
                    end
                end
                ST_DATA: begin
                    if (i_baud_pulse) begin
                        if (r_idx < LAST_IDX) begin
                            r_idx <= r_idx + IDX_W'(1);
                            r_tx  <= r_shift[0];
                        end else begin
`ifdef UART_TX_PARITY_EN
                            r_state <= ST_PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (i_baud_pulse) begin
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (i_baud_pulse) begin
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // Payload path; after a reset the stale byte is never emitted because
    // the next acceptance always overwrites it before START.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_shift <= w_sel_data;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^w_sel_data;
`endif
        end else if (w_shift) begin
            r_shift <= r_shift >> 1;
        end
    end

    assign o_tx         = r_tx;
    assign o_busy       = r_busy;
    assign o_grant_id   = r_grant_id;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (DATA_W=8, baud_pulse every 4 clk); frames are compared
// bit by bit against hand-computed words with bit 0 = first bit on the line.
module tb_uart_tx_arbiter;

    localparam int DATA_W = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [15:0] F_A5 = 16'h054A;
    localparam logic [15:0] F_11 = 16'h0422;
    localparam logic [15:0] F_22 = 16'h0444;
    localparam logic [15:0] F_3C = 16'h0478;
    localparam logic [15:0] F_07 = 16'h060E;
`else
    localparam int NB = 10;
    localparam logic [15:0] F_A5 = 16'h034A;
    localparam logic [15:0] F_11 = 16'h0222;
    localparam logic [15:0] F_22 = 16'h0244;
    localparam logic [15:0] F_3C = 16'h0278;
    localparam logic [15:0] F_07 = 16'h020E;
`endif

    logic clk;
    logic rst_n;
    logic baud;
    logic tx;
    logic busy;
    logic grant_id;
    logic frame_done;
    int   n_chk;
    int   n_fail;
    int   bcnt;
    int   sw;

    uart_tx_arbiter_if #(.DATA_W(DATA_W)) bus ();

    uart_tx_arbiter #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_baud_pulse (baud),
        .bus          (bus),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_grant_id   (grant_id),
        .o_frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        baud = 1'b0;
        bcnt = 0;
        forever begin
            @(negedge clk);
            bcnt = (bcnt + 1) % 4;
            baud = (bcnt == 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits for the start bit, samples every bit for its four clocks, then checks the done pulse.
    task automatic capture_frame(input string tag, input logic [15:0] exp_word,
                                 input logic exp_gid, output int sync_wait);
        logic [15:0] word;
        logic        steady;
        int          w;
        word   = '0;
        steady = 1'b1;
        w      = 0;
        @(negedge clk);
        while (tx !== 1'b0 && w < 40) begin
            w++;
            @(negedge clk);
        end
        sync_wait = w;
        if (w >= 40) begin
            chk({tag, " start_timeout"}, 32'd1, 32'd0);
            return;
        end
        chk({tag, " busy_in_frame"}, busy, 1'b1);
        for (int i = 0; i < NB; i++) begin
            word[i] = tx;
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                if (tx !== word[i]) steady = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, " bits"}, word, exp_word);
        chk({tag, " bit_len"}, steady, 1'b1);
        chk({tag, " frame_done"}, frame_done, 1'b1);
        chk({tag, " busy_after"}, busy, 1'b0);
        chk({tag, " grant_id"}, grant_id, exp_gid);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_data  = '0;

        // Reset held with random requester activity
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.req0_valid = 1'($urandom_range(0, 1));
            bus.req1_valid = 1'($urandom_range(0, 1));
            bus.req0_data  = 8'($urandom);
            bus.req1_data  = 8'($urandom);
            #1;
            chk("reset_outputs", {tx, busy, bus.req0_ready, bus.req1_ready, frame_done}, 5'b10000);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with baud pulses running
        begin
            logic quiet;
            quiet = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) quiet = 1'b0;
            end
            chk("idle_quiet", quiet, 1'b1);
            chk("idle_grant_id", grant_id, 1'b0);
        end

        // Single frame from req0
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'hA5;
        #1;
        chk("a5_ready0", bus.req0_ready, 1'b1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        chk("a5_busy_sync", {busy, tx, bus.req0_ready}, 3'b110);
        capture_frame("a5", F_A5, 1'b0, sw);
        @(negedge clk);
        chk("a5_done_one_clk", frame_done, 1'b0);

        // Tie after reset: req0 first, then req1
        do_reset();
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h11;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h22;
        #1;
        chk("tie_readys", {bus.req0_ready, bus.req1_ready}, 2'b10);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        chk("tie_first_grant", grant_id, 1'b0);
        chk("tie_ready1_busy", bus.req1_ready, 1'b0);
        capture_frame("tie_11", F_11, 1'b0, sw);
        chk("tie_ready1_idle", {bus.req0_ready, bus.req1_ready}, 2'b01);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        chk("tie_second_busy", busy, 1'b1);
        capture_frame("tie_22", F_22, 1'b1, sw);

        // req1 alone with 0x07
        @(negedge clk);
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h07;
        @(negedge clk);
        bus.req1_valid = 1'b0;
        capture_frame("r1_07", F_07, 1'b1, sw);

        // req1 streaming: back-to-back frames each wait in SYNC
        @(negedge clk);
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h22;
        capture_frame("stream_a", F_22, 1'b1, sw);
        capture_frame("stream_b", F_22, 1'b1, sw);
        bus.req1_valid = 1'b0;
        chk("stream_sync_wait", sw, 32'd3);
        repeat (3) @(negedge clk);
        chk("stream_idle", {busy, grant_id}, 2'b01);

        // Reset during data bit 3, then a clean frame
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h00;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        begin
            int w;
            w = 0;
            while (tx !== 1'b0 && w < 40) begin
                w++;
                @(negedge clk);
            end
            chk("abort_start_seen", (w < 40), 1'b1);
        end
        repeat (17) @(negedge clk);
        chk("abort_pre_reset", {tx, busy}, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_async", {tx, busy, frame_done, grant_id}, 4'b1000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_partial", {tx, busy}, 2'b10);
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h3C;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        capture_frame("after_abort_3c", F_3C, 1'b0, sw);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, the number of data bits per frame (5..9).
REQ-002 clk  input  1  system clock, 50 MHz.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 baud_pulse  input  1  one-clk strobe per bit period, from the baud rate generator.
REQ-005 req0_valid  input  1  requester 0 has a byte to send.
REQ-006 req0_data  input  DATA_W  requester 0 byte; held stable while req0_valid is high.
REQ-007 req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-008 req1_valid, req1_data, req1_ready  as REQ-005..007, for requester 1.
REQ-009 tx  output  1  serial line; idle high.
REQ-010 busy  output  1  a frame is in progress (state not IDLE).
REQ-011 grant_id  output  1  requester that owns the current or last frame.
REQ-012 frame_done  output  1  one-clk pulse when a stop bit completes.

Function
REQ-013 FSM states SHALL be IDLE, SYNC, START, DATA, PARITY, STOP; only one state is active at a time.
REQ-014 reqN_ready SHALL be combinational and asserted only in IDLE, for the single requester selected by REQ-015.
REQ-015 Arbitration SHALL be round-robin:
- only one valid: grant it;
- both valid: grant the requester that is not last_grant.
REQ-016 A transfer SHALL occur on a cycle with valid&&ready. On that cycle the FSM latches the data, updates grant_id/last_grant, and moves to SYNC.
REQ-017 SYNC: tx SHALL stay 1. On the next baud_pulse the FSM moves to START and tx goes to 0. A baud_pulse on the acceptance cycle itself SHALL be ignored.
REQ-018 START: on baud_pulse, move to DATA with tx = bit0 (LSB first) and the bit index cleared.
REQ-019 DATA: on baud_pulse, if the index is below DATA_W-1, output the next bit. Otherwise move to PARITY (macro defined) or STOP, with tx = parity or 1 respectively.
REQ-020 PARITY: on baud_pulse, move to STOP with tx = 1.
REQ-021 STOP: on baud_pulse, move to IDLE and pulse frame_done for exactly one clk. A new acceptance is possible from the following cycle.
REQ-022 Every bit SHALL last exactly one baud_pulse interval. tx SHALL be driven from a register (glitch-free).
REQ-023 baud_pulse in IDLE SHALL have no effect.
REQ-024 busy SHALL be registered, and high from the cycle after acceptance through the cycle STOP exits.
REQ-025 The bit index SHALL be sized to hold DATA_W-1 with no wrap inside a frame.

Reset
REQ-026 When rst_n=0, outputs SHALL immediately take these values: tx=1, busy=0, frame_done=0, grant_id=0, req0_ready=req1_ready=0, state=IDLE.
REQ-027 Reset SHALL set last_grant=1, so req0 wins the first tie.
REQ-028 Reset mid-frame SHALL abort the frame and discard the latched byte. After release, normal operation resumes with no partial bits.

Configuration
REQ-029 Macro UART_TX_PARITY_EN defined: PARITY state present, with an even parity bit (XOR of data bits) sent between the last data bit and stop; the frame is 1+DATA_W+1+1 bits.
REQ-030 UART_TX_PARITY_EN undefined: no PARITY state and no parity logic; the frame is 1+DATA_W+1 bits.

Verification (DATA_W=8, baud_pulse every 4 clk)
REQ-031 Hold rst_n=0 with random inputs -> tx=1, busy=0, both readys 0, frame_done 0.
REQ-032 req0 sends 0xA5, macro off -> after SYNC, tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 clk; frame_done once; grant_id=0.
REQ-033 req0=0x11 and req1=0x22 valid on the same cycle after reset -> 0x11 is sent first (grant_id 0), then 0x22 (grant_id 1); no overlap.
REQ-034 Macro on, req1 sends 0x07 -> parity bit 1 follows data bit 7, then stop 1; the frame is 11 bits.
REQ-035 rst_n pulsed low during data bit 3 -> tx=1 and busy=0 asynchronously. A following 0x3C from req0 is a clean, correct frame.
REQ-036 req1_valid held high continuously, req0 idle -> req1 granted for consecutive frames, each starting with a SYNC wait; a stop bit is never shortened.
